lsu_mem_if: RTL
===============

Name: lsu_mem_if

Overview:
- Load/store access unit in the MEM stage, at the receiving end of the CU memory controls (memwrite, memtoreg, wtype).
- Turns those controls plus the ALU address and store data into byte-enabled word transactions on a data-memory bus with variable latency.
- Returns sign- or zero-extended load data to writeback.
- Stalls the pipeline while a transaction is outstanding, and times out a memory that never responds.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles in WAIT before the access is aborted with bus_err. Legal range 2..255.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst_n  in  1  synchronous reset, active low
- ex_valid  in  1  MEM-stage instruction valid
- memwrite  in  1  store (SW/SH/SB)
- memtoreg  in  1  load (LW/LH/LB/LHU/LBU)
- wtype  in  3  bit0 byte, bit1 half, bit2 unsigned; 000 = word
- addr  in  32  byte address from ALU
- wdata  in  32  store data (rt)
- stall  out  1  freeze upstream stages
- ld_data  out  32  extended load result
- ld_valid  out  1  one-cycle pulse; ld_data valid
- bus_err  out  1  one-cycle pulse on timeout (or misalign, see below)
- mem_req  out  1  request strobe
- mem_we  out  1  1 = write
- mem_be  out  4  byte enables; bit i = addr byte i (little endian)
- mem_addr  out  32  word address; {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  memory accepted the request
- mem_rvalid  in  1  response: read data valid, or write acknowledge
- mem_rdata  in  32  read word

Behaviour:
Reset (rst_n low at a clock edge):
- state = IDLE; all outputs 0; counter 0.
- Asserting reset mid-transaction aborts it: mem_req drops the next cycle and no pulse is produced.

State machine, states IDLE, REQ, WAIT, DONE:
- IDLE:
  - An access starts when ex_valid & (memwrite|memtoreg).
  - On start, latch addr, wdata, wtype, and op (memwrite has priority when both memwrite and memtoreg are set); go to REQ.
  - mem_rvalid is ignored in IDLE.
- REQ:
  - mem_req=1; mem_we, mem_be, mem_addr and mem_wdata are driven from the latched fields and held stable.
  - Stay until mem_gnt=1, then clear the counter and go to WAIT.
  - There is no timeout in REQ.
- WAIT:
  - mem_req=0; the counter increments each cycle.
  - On mem_rvalid=1: for a load, register the extracted data into ld_data and pulse ld_valid; go to DONE. For a store, the response is an ack only.
  - If counter==TIMEOUT_CYCLES-1 with no mem_rvalid: pulse bus_err, set ld_data=0, go to DONE.
  - If mem_rvalid and the timeout coincide, mem_rvalid wins.
- DONE:
  - Lasts one cycle, then returns to IDLE.
  - ld_valid/bus_err are high only during DONE.
  - A new request is not accepted in DONE; it is accepted in IDLE the next cycle.

stall:
- stall = start_in_IDLE | (state==REQ) | (state==WAIT). This is combinational.
- stall is low in DONE.
- Upstream must hold its inputs stable while stall is high.
- Minimum access time is 3 cycles (gnt in the first REQ cycle, rvalid in the first WAIT cycle).

Store lanes:
- Byte: mem_be = 1<<addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
- Half: mem_be = addr[1] ? 1100 : 0011; mem_wdata = {2{wdata[15:0]}}.
- Word: mem_be = 1111; mem_wdata = wdata.
- wtype[1:0]=11 is treated as word.

Load extract:
- Byte: select lane addr[1:0].
- Half: select lane addr[1].
- Sign-extend unless wtype[2]=1, in which case zero-extend.
- For loads, mem_be = the same mask as for a store of that width.

Optional Feature:
MISALIGN_TRAP_EN:
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, never issues mem_req.
  - It goes IDLE -> DONE directly with bus_err pulsed, ld_data=0 and no ld_valid.
  - stall is high only in the start cycle.
- Undefined:
  - The offending low address bits are ignored: a half uses addr[1], a word uses lane 0.

Test Plan:
1. LB, addr=0x103, mem_rdata=0x80FF_1234, gnt in the first REQ cycle, rvalid after 2 WAIT cycles -> mem_be=1000, ld_data=0xFFFF_FF80, ld_valid one cycle, stall high for exactly 4 cycles.
2. LHU, addr=0x102, mem_rdata=0x9ABC_0000 -> ld_data=0x0000_9ABC. LH with the same stimulus -> ld_data=0xFFFF_9ABC.
3. SH, addr=0x202, wdata=0x1234_5678 -> mem_we=1, mem_be=1100, mem_wdata=0x5678_5678, mem_addr=0x200. mem_gnt held low 5 cycles -> mem_req stays high with all fields stable.
4. LW with no mem_rvalid and TIMEOUT_CYCLES=4 -> bus_err pulses 4 cycles after gnt, ld_data=0, no ld_valid, return to IDLE.
5. rst_n low during WAIT, then mem_rvalid arrives in IDLE -> no ld_valid and state stays IDLE. A following SB at addr=0x1 with wdata=0xAB -> mem_be=0010, mem_wdata=0xABAB_ABAB.
6. MISALIGN_TRAP_EN defined, LW at addr=0x6 -> no mem_req, bus_err in the next cycle, stall high for 1 cycle. Undefined -> mem_addr=0x4, mem_be=1111.

Source files
------------

// File: rtl/lsu_mem_if.sv
// MEM-stage load/store unit: issues byte-enabled word transactions on a variable-latency data bus.
// Optional `MISALIGN_TRAP_EN: misaligned half/word accesses are trapped with bus_err instead of issued.
module lsu_mem_if #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        memwrite,
  input  logic        memtoreg,
  input  logic [2:0]  wtype,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [2:0]       wtype_q, wtype_d;
  logic             isWrite_q, isWrite_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      ldData_q, ldData_d;
  logic             ldValid_q, ldValid_d;
  logic             busErr_q, busErr_d;

  logic        startAcc;
  logic [3:0]  beMask;
  logic [31:0] wdRep;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] extData;

  // wtype[1:0] = 11 falls through to the word case, same as 00
  always_comb begin
    beMask = 4'b1111;
    wdRep  = wdata_q;
    case (wtype_q[1:0])
      2'b01: begin
        beMask = 4'b0001 << addr_q[1:0];
        wdRep  = {4{wdata_q[7:0]}};
      end
      2'b10: begin
        beMask = addr_q[1] ? 4'b1100 : 4'b0011;
        wdRep  = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   byteSel = mem_rdata[7:0];
      2'b01:   byteSel = mem_rdata[15:8];
      2'b10:   byteSel = mem_rdata[23:16];
      default: byteSel = mem_rdata[31:24];
    endcase
    halfSel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    extData = mem_rdata;
    case (wtype_q[1:0])
      2'b01:   extData = wtype_q[2] ? {24'b0, byteSel} : {{24{byteSel[7]}}, byteSel};
      2'b10:   extData = wtype_q[2] ? {16'b0, halfSel} : {{16{halfSel[15]}}, halfSel};
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wtype_d   = wtype_q;
    isWrite_d = isWrite_q;
    cnt_d     = cnt_q;
    ldData_d  = ldData_q;
    ldValid_d = 1'b0;
    busErr_d  = 1'b0;
    startAcc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n && ex_valid && (memwrite || memtoreg)) begin
          startAcc  = 1'b1;
          addr_d    = addr;
          wdata_d   = wdata;
          wtype_d   = wtype;
          isWrite_d = memwrite;
`ifdef MISALIGN_TRAP_EN
          if (((wtype[1:0] == 2'b10) && addr[0]) ||
              ((wtype[1:0] != 2'b01) && (wtype[1:0] != 2'b10) && (addr[1:0] != 2'b00))) begin
            busErr_d = 1'b1;
            ldData_d = 32'b0;
            state_d  = DONE;
          end else begin
            state_d = REQ;
          end
`else
          state_d = REQ;
`endif
        end
      end
      REQ: begin
        if (mem_gnt) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A response arriving on the last allowed cycle still completes normally
        if (mem_rvalid) begin
          if (!isWrite_q) begin
            ldData_d  = extData;
            ldValid_d = 1'b1;
          end
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          busErr_d = 1'b1;
          ldData_d = 32'b0;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wtype_q   <= '0;
      isWrite_q <= 1'b0;
      cnt_q     <= '0;
      ldData_q  <= '0;
      ldValid_q <= 1'b0;
      busErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wtype_q   <= wtype_d;
      isWrite_q <= isWrite_d;
      cnt_q     <= cnt_d;
      ldData_q  <= ldData_d;
      ldValid_q <= ldValid_d;
      busErr_q  <= busErr_d;
    end
  end

  // Bus fields are only driven while the request is presented
  always_comb begin
    stall     = startAcc || (state_q == REQ) || (state_q == WAIT);
    mem_req   = (state_q == REQ);
    mem_we    = mem_req && isWrite_q;
    mem_be    = mem_req ? beMask : 4'b0;
    mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'b0;
    mem_wdata = mem_req ? wdRep : 32'b0;
    ld_data   = ldData_q;
    ld_valid  = ldValid_q;
    bus_err   = busErr_q;
  end

endmodule
